mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit up-counter.
- Adds runtime modulus, up/down direction, synchronous load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used as a general event/timer counter in control and datapath logic.
- Optional clock-enable prescaler for slow timebases.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- PRESCALE, 4, enable divide ratio when prescaler is compiled in (1..256; 1 = no division).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  count-step request, sampled each cycle.
- up_dn  in  1  direction: 1 = up, 0 = down.
- sat_mode  in  1  1 = saturate at boundary, 0 = wrap.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- mod_val  in  WIDTH  modulus; count range is 0..mod_val-1; 0 means 2^WIDTH.
- clr_flag  in  1  clears ovf.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, 1 cycle.
- ovf  out  1  sticky boundary-hit flag.

Behaviour:
- Reset (async assert, sync-safe release): count=0, tc=0, ovf=0, prescaler=0.
- MAX = mod_val-1. When mod_val=0, MAX = 2^WIDTH-1. All arithmetic is WIDTH bits, unsigned.
- Per-cycle priority: reset > load > step > hold. A step occurs when enable=1 (and, if compiled in, the prescaler tick=1).
- load: count <= min(load_val, MAX). tc=0 that cycle. load overrides a simultaneous step. The prescaler is not reset by load.
- Up step:
  - count < MAX: count+1.
  - count >= MAX: boundary. Wrap mode -> 0; sat mode -> MAX.
- Down step:
  - 0 < count <= MAX: count-1.
  - count == 0: boundary. Wrap mode -> MAX; sat mode -> 0.
  - count > MAX (modulus lowered at runtime): count <= MAX, not a boundary.
- Boundary step: tc=1 in the next cycle, for exactly one cycle. This repeats on every boundary step, including repeated saturated steps. The same boundary step sets ovf.
- ovf stays set until clr_flag=1. If clr_flag coincides with a boundary step, the set wins (ovf stays 1).
- tc is 0 in every cycle that does not follow a boundary step.
- No step (enable=0 or no tick): count holds, tc=0.
- Latency: one clock from step/load to the new count.
- mod_val, up_dn and sat_mode are sampled every cycle. Changing them mid-count takes effect on the next step, with no glitch on count.
- mod_val=1: MAX=0. Every step is a boundary step, count stays 0, tc pulses on every step.

Optional Feature:
- Macro: MOD_COUNTER_PRESCALE_EN.
- Defined:
  - An internal ceil(log2(PRESCALE))-bit prescaler increments on each enable=1 cycle.
  - A tick is produced when the prescaler reaches PRESCALE-1; the prescaler then returns to 0.
  - A step occurs only on enable && tick.
  - enable=0 holds the prescaler.
  - PRESCALE=1 gives a tick every enable cycle.
- Not defined: no prescaler logic. A step occurs on every enable=1 cycle, and PRESCALE is ignored.

Decomposition:
- Shared package counter_pkg:
  - typedef cnt_dir_e {CNT_DOWN=0, CNT_UP=1}.
  - typedef cnt_mode_e {CNT_WRAP=0, CNT_SAT=1}.
  - localparam helper function for the prescaler width.
- One sub-module: cnt_prescaler.
  - Parameter: PRESCALE.
  - Ports: clk, reset, enable, tick.
  - Instantiated only under MOD_COUNTER_PRESCALE_EN.

Test Plan (WIDTH=8, prescaler off unless stated):
- Reset mid-count at count=0x37 -> count=0, tc=0, ovf=0 immediately. This holds with no clock edge.
- mod_val=10, up, wrap, enable held -> 0..9, 0. tc=1 in the cycle count shows 0 after 9. ovf=1 and stays until clr_flag.
- mod_val=0, down, sat, from 0x02 -> 1, 0, 0, 0. tc pulses on each step taken at 0. count never reaches 0xFF.
- load=1 with load_val=0x50, mod_val=0x20, enable=1 same cycle -> count=0x1F, no step applied, tc=0.
- count=0x30, then mod_val changed to 0x10. Up step -> 0 with tc pulse. Down step instead -> 0x0F with no tc.
- MOD_COUNTER_PRESCALE_EN, PRESCALE=4, enable held 12 cycles from 0 -> count=3. Steps occur on enable cycles 4, 8 and 12.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulus counter family.
// Configuration macro used by the counter: MOD_COUNTER_PRESCALE_EN.
package counter_pkg;

   // Count direction as presented on up_dn.
   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } cnt_dir_e;

   // Boundary behaviour as presented on sat_mode.
   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   // Width of a prescaler that counts 0..ratio-1, never less than one bit.
   function automatic int prescale_width(input int ratio);
      int w;
      w = 1;
      for (int i = 1; i <= 8; i++) begin
         if ((32'd1 << i) < ratio) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable divider: produces one tick every PRESCALE enabled cycles.
// Only instantiated when MOD_COUNTER_PRESCALE_EN is defined.
module cnt_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int            PW     = prescale_width(PRESCALE);
   localparam logic [PW-1:0] LAST_C = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] ZERO_C = {PW{1'b0}};
   localparam logic [PW-1:0] ONE_C  = PW'(1);

   logic [PW-1:0] pre_r;
   logic [PW-1:0] pre_nxt_s;
   logic          at_last_s;

   // Advance on enabled cycles, returning to zero after the last phase.
   always_comb begin
      pre_nxt_s = pre_r;
      at_last_s = (pre_r == LAST_C);
      if (enable) begin
         if (at_last_s) begin
            pre_nxt_s = ZERO_C;
         end else begin
            pre_nxt_s = pre_r + ONE_C;
         end
      end else begin
         pre_nxt_s = pre_r;
      end
   end

   // Prescaler phase register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_r <= ZERO_C;
      end else begin
         pre_r <= pre_nxt_s;
      end
   end

   // Tick is qualified by enable so a held prescaler never fires.
   assign tick = enable & at_last_s;

endmodule

// File: rtl/mod_updown_counter.sv
// Runtime-modulus up/down counter with load, wrap/saturate, terminal-count
// pulse and sticky overflow flag.
// Optional enable prescaler is compiled in with MOD_COUNTER_PRESCALE_EN.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_val,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C      = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL_ONES_C = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] count_nxt_s;
   logic [WIDTH-1:0] max_s;
   logic             tc_r;
   logic             ovf_r;
   logic             ovf_nxt_s;
   logic             tick_s;
   logic             step_s;
   logic             boundary_s;
   cnt_dir_e         dir_s;
   cnt_mode_e        mode_s;

   assign dir_s  = cnt_dir_e'(up_dn);
   assign mode_s = cnt_mode_e'(sat_mode);

`ifdef MOD_COUNTER_PRESCALE_EN
   cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick_s)
   );
`else
   assign tick_s = 1'b1;
`endif

   assign step_s = enable & tick_s;

   // Largest legal count; a zero modulus selects the full 2^WIDTH range.
   always_comb begin
      if (mod_val == ZERO_C) begin
         max_s = ALL_ONES_C;
      end else begin
         max_s = mod_val - ONE_C;
      end
   end

   // Next count and boundary detection: load beats step, step beats hold.
   always_comb begin
      count_nxt_s = count_r;
      boundary_s  = 1'b0;
      if (load) begin
         if (load_val > max_s) begin
            count_nxt_s = max_s;
         end else begin
            count_nxt_s = load_val;
         end
      end else if (step_s) begin
         case (dir_s)
            CNT_UP: begin
               if (count_r < max_s) begin
                  count_nxt_s = count_r + ONE_C;
               end else begin
                  boundary_s  = 1'b1;
                  count_nxt_s = (mode_s == CNT_SAT) ? max_s : ZERO_C;
               end
            end
            CNT_DOWN: begin
               if (count_r == ZERO_C) begin
                  boundary_s  = 1'b1;
                  count_nxt_s = (mode_s == CNT_SAT) ? ZERO_C : max_s;
               end else if (count_r > max_s) begin
                  // Modulus was lowered under the count: pull back in range.
                  count_nxt_s = max_s;
               end else begin
                  count_nxt_s = count_r - ONE_C;
               end
            end
            default: begin
               count_nxt_s = count_r;
            end
         endcase
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Sticky overflow: a boundary hit outranks a simultaneous clear.
   always_comb begin
      if (boundary_s) begin
         ovf_nxt_s = 1'b1;
      end else if (clr_flag) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
   end

   // Output registers; tc is a one-cycle echo of the boundary step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= ZERO_C;
         tc_r    <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         tc_r    <= boundary_s;
         ovf_r   <= ovf_nxt_s;
      end
   end

   assign count = count_r;
   assign tc    = tc_r;
   assign ovf   = ovf_r;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=8, PRESCALE=4).
// Directed vectors, corner sequences and randomized traffic against a
// behavioural model. Prescaler sequence runs when MOD_COUNTER_PRESCALE_EN is set.
module tb_mod_updown_counter;

   localparam int W = 8;
   localparam int P = 4;

   logic         clk;
   logic         reset;
   logic         enable;
   logic         up_dn;
   logic         sat_mode;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] mod_val;
   logic         clr_flag;
   logic [W-1:0] count;
   logic         tc;
   logic         ovf;

   int n_checks;
   int n_fail;

   // Behavioural reference state
   int m_cnt;
   int m_tc;
   int m_ovf;
   int m_pre;

   typedef struct {
      logic         en;
      logic         up;
      logic         sat;
      logic         ld;
      logic [W-1:0] lv;
      logic [W-1:0] mv;
      logic         clr;
      logic [W-1:0] e_cnt;
      logic         e_tc;
      logic         e_ovf;
   } vec_t;

   vec_t vecs [14];

   mod_updown_counter #(.WIDTH(W), .PRESCALE(P)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .up_dn    (up_dn),
      .sat_mode (sat_mode),
      .load     (load),
      .load_val (load_val),
      .mod_val  (mod_val),
      .clr_flag (clr_flag),
      .count    (count),
      .tc       (tc),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_tc  = 0;
      m_ovf = 0;
      m_pre = 0;
   endtask

   // Reference rules in plain integer arithmetic.
   task automatic model_clock();
      int mx;
      int stp;
      int bnd;
      mx  = (mod_val == 0) ? (1 << W) - 1 : int'(mod_val) - 1;
`ifdef MOD_COUNTER_PRESCALE_EN
      stp = 0;
      if (enable) begin
         stp   = (m_pre == P - 1) ? 1 : 0;
         m_pre = (m_pre + 1) % P;
      end
`else
      stp = enable ? 1 : 0;
`endif
      bnd = 0;
      if (load) begin
         m_cnt = (int'(load_val) > mx) ? mx : int'(load_val);
      end else if (stp != 0) begin
         if (up_dn) begin
            if (m_cnt < mx) m_cnt = m_cnt + 1;
            else begin
               bnd   = 1;
               m_cnt = sat_mode ? mx : 0;
            end
         end else begin
            if (m_cnt == 0) begin
               bnd   = 1;
               m_cnt = sat_mode ? 0 : mx;
            end else if (m_cnt > mx) m_cnt = mx;
            else m_cnt = m_cnt - 1;
         end
      end
      m_tc = bnd;
      if (bnd != 0) m_ovf = 1;
      else if (clr_flag) m_ovf = 0;
   endtask

   // One clock: model follows the DUT edge, sampling point is 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      if (reset) model_reset();
      else model_clock();
      #1;
   endtask

   task automatic set_in(input logic en, input logic up, input logic sat, input logic ld,
                         input logic [W-1:0] lv, input logic [W-1:0] mv, input logic clr);
      enable   = en;
      up_dn    = up;
      sat_mode = sat;
      load     = ld;
      load_val = lv;
      mod_val  = mv;
      clr_flag = clr;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      model_reset();
      cycle();
      reset = 1'b0;
   endtask

   task automatic cmp_model(input string tag);
      check({tag, "_count"}, 32'(count), 32'(m_cnt));
      check({tag, "_tc"},    32'(tc),    32'(m_tc));
      check({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_reset();
      reset = 1'b0;
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

      // Power-on reset, checked before any clock edge
      #1 reset = 1'b1;
      #1;
      check("por_count", 32'(count), 32'd0);
      check("por_tc",    32'(tc),    32'd0);
      check("por_ovf",   32'(ovf),   32'd0);
      cycle();
      cycle();
      reset = 1'b0;

`ifndef MOD_COUNTER_PRESCALE_EN
      // Directed vector table, applied back to back from the reset state
      //           en    up    sat   ld    lv     mv     clr   cnt    tc    ovf
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h50, 8'h20, 1'b0, 8'h1F, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 8'h1F, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 8'h1F, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 8'h1F, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 8'h00, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 8'h0F, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 8'h00, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 8'h0F, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 8'h0F, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
      for (int v = 0; v < 14; v++) begin
         set_in(vecs[v].en, vecs[v].up, vecs[v].sat, vecs[v].ld,
                vecs[v].lv, vecs[v].mv, vecs[v].clr);
         cycle();
         check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].e_cnt));
         check($sformatf("vec%0d_tc", v),    32'(tc),    32'(vecs[v].e_tc));
         check($sformatf("vec%0d_ovf", v),   32'(ovf),   32'(vecs[v].e_ovf));
      end

      // Modulus 10, up, wrap: 1..9 then 0 with tc and ovf
      do_reset();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd10, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         cycle();
         check($sformatf("m10_count%0d", i), 32'(count), 32'(i % 10));
         check($sformatf("m10_tc%0d", i),    32'(tc),    (i == 10) ? 32'd1 : 32'd0);
         check($sformatf("m10_ovf%0d", i),   32'(ovf),   (i == 10) ? 32'd1 : 32'd0);
      end
      enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("m10_hold_count", 32'(count), 32'd0);
         check("m10_hold_tc",    32'(tc),    32'd0);
         check("m10_hold_ovf",   32'(ovf),   32'd1);
      end
      clr_flag = 1'b1;
      cycle();
      check("m10_clr_ovf", 32'(ovf), 32'd0);

      // Full range, down, saturate from 2: 1,0,0,0 with tc on steps at 0
      do_reset();
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 1'b0);
      cycle();
      check("dsat_load", 32'(count), 32'd2);
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check($sformatf("dsat_count%0d", i), 32'(count), (i == 0) ? 32'd1 : 32'd0);
         check($sformatf("dsat_tc%0d", i),    32'(tc),    (i >= 2) ? 32'd1 : 32'd0);
      end

      // Asynchronous reset mid-count with ovf set, no clock edge needed
      do_reset();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
      cycle();
      check("arst_pre_ovf", 32'(ovf), 32'd1);
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h37, 8'h00, 1'b0);
      cycle();
      check("arst_pre_count", 32'(count), 32'h37);
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      #1 reset = 1'b1;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_tc",    32'(tc),    32'd0);
      check("arst_ovf",   32'(ovf),   32'd0);
      model_reset();
      cycle();
      reset = 1'b0;
`else
      // Prescaler 4, enable held 12 cycles: steps on enable cycles 4, 8, 12
      do_reset();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         cycle();
         check($sformatf("pre_count%0d", i), 32'(count), 32'(i / 4));
         check($sformatf("pre_tc%0d", i),    32'(tc),    32'd0);
      end
`endif

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int sel;
         logic [W-1:0] mv;
         sel = int'($urandom_range(0, 4));
         case (sel)
            0:       mv = 8'h00;
            1:       mv = 8'h01;
            2:       mv = 8'd10;
            3:       mv = 8'h20;
            default: mv = W'($urandom_range(0, 255));
         endcase
         set_in(($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                W'($urandom_range(0, 255)),
                mv,
                ($urandom_range(0, 7) == 0));
         cycle();
         cmp_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
